// File: rtl/seq_subtractor_if.sv
// -----------------------------------------------------------------------------
// seq_subtractor_if
//   Handshake and data bus of the sequential subtractor.
//   Operand side : in_valid, in_ready, a, b
//   Result side  : out_valid, out_ready, diff, bo, ovf
//   ovf exists only when SEQ_SUBTRACTOR_OVF_EN is defined.
//   Modports: master = operand producer / result consumer, slave = subtractor.
// -----------------------------------------------------------------------------
interface seq_subtractor_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] diff;
  logic                  bo;
`ifdef SEQ_SUBTRACTOR_OVF_EN
  logic                  ovf;
`endif

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, bo
`ifdef SEQ_SUBTRACTOR_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, bo
`ifdef SEQ_SUBTRACTOR_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/seq_subtractor.sv
// -----------------------------------------------------------------------------
// seq_subtractor
//   Multi-cycle a - b, one CHUNK_WIDTH slice per clock, LSB slice first.
//   A transaction is accepted in IDLE, computed over DATA_WIDTH/CHUNK_WIDTH
//   BUSY cycles and held in DONE until the consumer takes it.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - seq_subtractor_if.slave (in_valid/in_ready/a/b,
//            out_valid/out_ready/diff/bo[/ovf])
//
//   Configuration macro: SEQ_SUBTRACTOR_OVF_EN
//     defined   -> ovf port and signed-overflow logic present
//     undefined -> ovf absent, everything else identical
// -----------------------------------------------------------------------------
module seq_subtractor #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  seq_subtractor_if.slave   bus
);

  localparam int NUM_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : g_width_check
    $error("seq_subtractor: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic                  borrow;
  logic [DATA_WIDTH-1:0] a_r;
  logic [DATA_WIDTH-1:0] b_r;
  logic [DATA_WIDTH-1:0] diff_r;
  logic                  in_ready_r;
  logic                  out_valid_r;
`ifdef SEQ_SUBTRACTOR_OVF_EN
  logic                  ovf_r;
`endif

  // Current slice arithmetic: a + ~b + ~borrow, i.e. a - b - borrow.
  logic [CHUNK_WIDTH-1:0] a_slice;
  logic [CHUNK_WIDTH-1:0] b_slice;
  logic [CHUNK_WIDTH:0]   slice_sum;
  logic                   slice_borrow;

  // NOTE: every combinational output is assigned on every path, so no latch
  // can be inferred; all assignments here are blocking.
  always_comb begin
    a_slice      = a_r[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
    b_slice      = b_r[cnt*CHUNK_WIDTH +: CHUNK_WIDTH];
    slice_sum    = {1'b0, a_slice} + {1'b0, ~b_slice} + {{CHUNK_WIDTH{1'b0}}, ~borrow};
    // A carry out of a + ~b + 1 means no borrow was needed.
    slice_borrow = ~slice_sum[CHUNK_WIDTH];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand registers are reset along with the rest; they are few
      // flops and it keeps every observable value deterministic after reset.
      state       <= IDLE;
      cnt         <= '0;
      borrow      <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      diff_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
`ifdef SEQ_SUBTRACTOR_OVF_EN
      ovf_r       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r        <= bus.a;
            b_r        <= bus.b;
            borrow     <= 1'b0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
          end
        end

        BUSY: begin
          diff_r[cnt*CHUNK_WIDTH +: CHUNK_WIDTH] <= slice_sum[CHUNK_WIDTH-1:0];
          borrow <= slice_borrow;
          if (cnt == LAST_CHUNK) begin
            out_valid_r <= 1'b1;
            state       <= DONE;
`ifdef SEQ_SUBTRACTOR_OVF_EN
            // Signed overflow: operand signs differ and the result sign
            // differs from the minuend sign. The MSB of diff is the MSB of
            // the slice being written on this very edge.
            ovf_r <= (a_r[DATA_WIDTH-1] != b_r[DATA_WIDTH-1]) &&
                     (slice_sum[CHUNK_WIDTH-1] != a_r[DATA_WIDTH-1]);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state       <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.diff      = diff_r;
  // After the MSB slice the borrow register holds the final borrow.
  assign bus.bo        = borrow;
`ifdef SEQ_SUBTRACTOR_OVF_EN
  assign bus.ovf       = ovf_r;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// -----------------------------------------------------------------------------
// tb_seq_subtractor
//   Directed self-checking bench for seq_subtractor at default parameters.
//   ovf is compared only when SEQ_SUBTRACTOR_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_seq_subtractor;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_subtractor_if #(.DATA_WIDTH(32)) bus ();

  seq_subtractor #(
    .DATA_WIDTH (32),
    .CHUNK_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair (block assumed idle), then wait for out_valid.
  // lat = number of edges after the handshake edge until out_valid is seen.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        output int lat, output logic [31:0] d,
                        output logic bo_o, output logic ovf_o);
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    d    = bus.diff;
    bo_o = bus.bo;
`ifdef SEQ_SUBTRACTOR_OVF_EN
    ovf_o = bus.ovf;
`else
    ovf_o = 1'b0;
`endif
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.diff !== 32'h0) begin errors++; $display("FAIL reset_diff got=%h exp=0", bus.diff); end
    checks++; if (bus.bo !== 1'b0) begin errors++; $display("FAIL reset_bo got=%b exp=0", bus.bo); end
`ifdef SEQ_SUBTRACTOR_OVF_EN
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
`endif
  endtask

  // Table of directed vectors with hand-computed results.
  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] diff;
    logic        bo;
    logic        ovf;
  } vec_t;

  task automatic test_vectors();
    vec_t vecs[5];
    int   lat;
    logic [31:0] d;
    logic bo_o, ovf_o;
    vecs[0] = '{"basic",      32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0};
    vecs[1] = '{"ripple",     32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{"signed_ovf", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[3] = '{"equal",      32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1'b0};
    vecs[4] = '{"mixed",      32'h1234_5678, 32'h8765_4321, 32'h8ACF_1357, 1'b1, 1'b1};
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat, d, bo_o, ovf_o);
      // Handshake edge, then four BUSY edges: out_valid seen after the 4th.
      checks++; if (lat != 4) begin errors++; $display("FAIL %s_latency got=%0d exp=4", vecs[i].name, lat); end
      checks++; if (d !== vecs[i].diff) begin errors++; $display("FAIL %s_diff got=%h exp=%h", vecs[i].name, d, vecs[i].diff); end
      checks++; if (bo_o !== vecs[i].bo) begin errors++; $display("FAIL %s_bo got=%b exp=%b", vecs[i].name, bo_o, vecs[i].bo); end
`ifdef SEQ_SUBTRACTOR_OVF_EN
      checks++; if (ovf_o !== vecs[i].ovf) begin errors++; $display("FAIL %s_ovf got=%b exp=%b", vecs[i].name, ovf_o, vecs[i].ovf); end
`endif
      release_result();
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL %s_release got out_valid=%b in_ready=%b exp 0/1", vecs[i].name, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_out_ready_ignored();
    bus.out_ready = 1'b1;
    tick();
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_out_ready got out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_hold();
    int   lat;
    logic [31:0] d;
    logic bo_o, ovf_o;
    run_op(32'h0000_0100, 32'h0000_0001, lat, d, bo_o, ovf_o);
    checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL hold_first_diff got=%h exp=000000ff", d); end
    // Stall in DONE while offering a new pair that must be ignored.
    bus.a        = 32'h0000_FFFF;
    bus.b        = 32'h0000_0001;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                    bus.diff !== 32'h0000_00FF || bus.bo !== 1'b0) begin
        errors++; $display("FAIL hold_stall cyc=%0d got in_ready=%b out_valid=%b diff=%h bo=%b exp 0/1/000000ff/0",
                           i, bus.in_ready, bus.out_valid, bus.diff, bus.bo);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL hold_release got out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
    end
    // in_valid is still high: accepted on this edge.
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL hold_accept got in_ready=%b exp=0", bus.in_ready); end
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("FAIL hold_second_latency got=%0d exp=4", lat); end
    checks++; if (bus.diff !== 32'h0000_FFFE || bus.bo !== 1'b0) begin
      errors++; $display("FAIL hold_second_result got diff=%h bo=%b exp 0000fffe/0", bus.diff, bus.bo);
    end
    release_result();
  endtask

  task automatic test_reset_abort();
    int   lat;
    logic [31:0] d;
    logic bo_o, ovf_o;
    bus.a        = 32'h1234_5678;
    bus.b        = 32'h1111_1111;
    bus.in_valid = 1'b1;
    tick();                 // handshake edge
    bus.in_valid = 1'b0;
    tick();                 // first BUSY edge; now in the second BUSY cycle
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== 32'h0 || bus.bo !== 1'b0) begin
      errors++; $display("FAIL abort_state got out_valid=%b in_ready=%b diff=%h bo=%b exp 0/1/00000000/0",
                         bus.out_valid, bus.in_ready, bus.diff, bus.bo);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result got out_valid=%b exp=0", bus.out_valid); end
    run_op(32'h1234_5678, 32'h1111_1111, lat, d, bo_o, ovf_o);
    checks++; if (lat != 4 || d !== 32'h0123_4567 || bo_o !== 1'b0) begin
      errors++; $display("FAIL abort_rerun got lat=%0d diff=%h bo=%b exp 4/01234567/0", lat, d, bo_o);
    end
`ifdef SEQ_SUBTRACTOR_OVF_EN
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL abort_rerun_ovf got=%b exp=0", ovf_o); end
`endif
    release_result();
  endtask

  task automatic test_back_to_back();
    int   lat;
    logic [31:0] d;
    logic bo_o, ovf_o;
    run_op(32'h0000_0007, 32'h0000_0008, lat, d, bo_o, ovf_o);
    checks++; if (d !== 32'hFFFF_FFFF || bo_o !== 1'b1) begin
      errors++; $display("FAIL b2b_first got diff=%h bo=%b exp ffffffff/1", d, bo_o);
    end
    release_result();
    // Next pair offered immediately in the cycle after the output handshake.
    run_op(32'hA5A5_A5A5, 32'h5A5A_5A5A, lat, d, bo_o, ovf_o);
    checks++; if (lat != 4 || d !== 32'h4B4B_4B4B || bo_o !== 1'b0) begin
      errors++; $display("FAIL b2b_second got lat=%0d diff=%h bo=%b exp 4/4b4b4b4b/0", lat, d, bo_o);
    end
`ifdef SEQ_SUBTRACTOR_OVF_EN
    checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL b2b_second_ovf got=%b exp=1", ovf_o); end
`endif
    release_result();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    test_reset();
    test_vectors();
    test_out_ready_ignored();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
